// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 (x^7+x^6+1) receive checker with lock detection and error counting
// Ports: clk/rst (async active-high) | in_valid, in_bit: serial input, only valid bits advance state |
//        clear_errs: sync clear of err_count | locked: in LOCKED | err_pulse: registered per-error pulse |
//        err_count: saturating count of mismatches seen while locked
module prbs7_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;
  state_t        r_state, w_state;
  logic [6:0]    r_s, w_s;
  logic [2:0]    r_fill, w_fill;
  logic [7:0]    r_match, w_match;
  logic [WW-1:0] r_win, w_win;
  logic [EW-1:0] r_werr, w_werr;
  logic          w_pred, w_mis, w_err;
  assign w_pred = r_s[6] ^ r_s[5];
  assign w_mis  = in_bit ^ w_pred;
  assign w_err  = in_valid && r_state == LOCKED && w_mis;
  assign locked = r_state == LOCKED;
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_fill  = r_fill;
    w_match = r_match;
    w_win   = r_win;
    w_werr  = r_werr;
    if (in_valid) begin
      // once locked the register free-runs on its own prediction so channel errors do not propagate
      w_s = {r_s[5:0], r_state == LOCKED ? w_pred : in_bit};
      unique case (r_state)
        SEED: begin
          w_fill = r_fill + 3'd1;
          if (r_fill == 3'd6) begin
            w_state = VERIFY;
            w_match = '0;
          end
        end
        VERIFY: begin
          if (w_mis) begin
            w_state = SEED;
            w_fill  = '0;
          end else begin
            w_match = r_match + 8'd1;
            if (w_match == 8'(LOCK_COUNT)) begin
              w_state = LOCKED;
              w_win   = '0;
              w_werr  = '0;
            end
          end
        end
        LOCKED: begin
          w_werr = r_werr + EW'(w_mis);
          if (w_mis && w_werr == EW'(UNLOCK_ERRS)) begin
            w_state = SEED;
            w_fill  = '0;
          end else if (r_win == WW'(WINDOW - 1)) begin
            w_win  = '0;
            w_werr = '0;
          end else begin
            w_win = r_win + WW'(1);
          end
        end
        default: w_state = SEED;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEED;
      r_s       <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_win     <= '0;
      r_werr    <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      r_state   <= w_state;
      r_s       <= w_s;
      r_fill    <= w_fill;
      r_match   <= w_match;
      r_win     <= w_win;
      r_werr    <= w_werr;
      err_pulse <= w_err;
      err_count <= clear_errs ? '0 : (w_err && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
    end
  end
endmodule
